// File: rtl/axi_lite_gpio_pkg.sv
// Shared definitions for the AXI4-Lite GPIO block: response codes, port
// limits, default register-map placement and small decode/merge helpers.
package axi_lite_gpio_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int MAX_PORTS      = 4;
    localparam int DEF_GPO_OFFSET = 32'h0000_0000;
    localparam int DEF_GPI_OFFSET = 32'h0000_0010;
    localparam int DEF_ADDR_INC   = 32'd4;

    // Result of matching a word address against a bank of ports.
    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } port_hit_t;

    // Match addr[7:2] against base + k*stride for every active port k.
    function automatic port_hit_t port_decode(
        input logic [5:0] word_addr,
        input int         base,
        input int         stride,
        input int         count
    );
        port_hit_t  res;
        logic [7:0] hit_addr;
        res = '{hit: 1'b0, idx: 2'b00};
        for (int k = 0; k < MAX_PORTS; k++) begin
            hit_addr = 8'(base + k * stride);
            if ((k < count) && (word_addr == hit_addr[7:2])) begin
                res.hit = 1'b1;
                res.idx = 2'(k);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Byte-lane merge of new write data into the current register value.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_gpio_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the GPIO
// block (slave). Clock and reset are carried as plain ports.
interface axi_lite_gpio_if;

    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_gpio_in_sync.sv
// 32-bit two-flop synchronizer for an asynchronous GPIO input port.
// Both stages clear to 0 on the synchronous reset.
module gpio_in_sync (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d,
    output logic [31:0] q
);

    logic [31:0] meta_r;
    logic [31:0] sync_r;

    // Two-stage capture of the pin value into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 32'h0000_0000;
            sync_r <= 32'h0000_0000;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/axi_lite_gpio.sv
// AXI4-Lite GPIO slave: up to four output registers and four input ports.
// Optional macro AXI_GPIO_IN_SYNC_EN inserts a two-flop synchronizer on
// each active input port; without it inputs are sampled directly.
module axi_lite_gpio
    import axi_lite_gpio_pkg::*;
#(
    parameter int I_PORT_COUNT        = 1,
    parameter int O_PORT_COUNT        = 1,
    parameter int GPO_AXI_ADDR_OFFSET = DEF_GPO_OFFSET,
    parameter int GPI_AXI_ADDR_OFFSET = DEF_GPI_OFFSET,
    parameter int ADDR_INC            = DEF_ADDR_INC
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    axi_lite_gpio_if.slave        s_axi,
    input  logic [31:0]           in0,
    input  logic [31:0]           in1,
    input  logic [31:0]           in2,
    input  logic [31:0]           in3,
    output logic [31:0]           out0,
    output logic [31:0]           out1,
    output logic [31:0]           out2,
    output logic [31:0]           out3
);

    // Write-side state: independent AW/W holding buffers and B response.
    logic                          aw_buf_r;
    logic [5:0]                    aw_word_r;
    logic                          w_buf_r;
    logic [31:0]                   w_data_r;
    logic [3:0]                    w_strb_r;
    logic                          bvalid_r;
    logic [1:0]                    bresp_r;
    logic [MAX_PORTS-1:0][31:0]    out_r;

    // Read-side state.
    logic                          rvalid_r;
    logic [31:0]                   rdata_r;
    logic [1:0]                    rresp_r;

    logic                          awready_s;
    logic                          wready_s;
    logic                          arready_s;
    logic                          aw_hs_s;
    logic                          w_hs_s;
    logic                          ar_hs_s;
    logic                          commit_s;
    port_hit_t                     wr_dec_s;
    port_hit_t                     rd_gpo_s;
    port_hit_t                     rd_gpi_s;
    logic [31:0]                   rd_data_s;
    logic [1:0]                    rd_resp_s;
    logic [MAX_PORTS-1:0][31:0]    in_raw_s;
    logic [MAX_PORTS-1:0][31:0]    in_smp_s;
    logic                          unused_s;

    assign in_raw_s = {in3, in2, in1, in0};

`ifdef AXI_GPIO_IN_SYNC_EN
    for (genvar k = 0; k < MAX_PORTS; k++) begin : g_in
        if (k < I_PORT_COUNT) begin : g_sync
            gpio_in_sync u_sync (
                .clk (s_axi_aclk),
                .rst (s_axi_areset),
                .d   (in_raw_s[k]),
                .q   (in_smp_s[k])
            );
        end else begin : g_off
            assign in_smp_s[k] = 32'h0000_0000;
        end
    end
`else
    for (genvar k = 0; k < MAX_PORTS; k++) begin : g_in
        if (k < I_PORT_COUNT) begin : g_direct
            assign in_smp_s[k] = in_raw_s[k];
        end else begin : g_off
            assign in_smp_s[k] = 32'h0000_0000;
        end
    end
`endif

    // Handshake readies are derived purely from registered state.
    assign awready_s = !aw_buf_r && !bvalid_r;
    assign wready_s  = !w_buf_r  && !bvalid_r;
    assign arready_s = !rvalid_r;
    assign aw_hs_s   = s_axi.awvalid && awready_s;
    assign w_hs_s    = s_axi.wvalid  && wready_s;
    assign ar_hs_s   = s_axi.arvalid && arready_s;
    assign commit_s  = aw_buf_r && w_buf_r;

    assign wr_dec_s = port_decode(aw_word_r, GPO_AXI_ADDR_OFFSET, ADDR_INC, O_PORT_COUNT);
    assign rd_gpo_s = port_decode(s_axi.araddr[7:2], GPO_AXI_ADDR_OFFSET, ADDR_INC, O_PORT_COUNT);
    assign rd_gpi_s = port_decode(s_axi.araddr[7:2], GPI_AXI_ADDR_OFFSET, ADDR_INC, I_PORT_COUNT);

    // Read data/response selection for the address currently on AR.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        rd_resp_s = RESP_SLVERR;
        if (rd_gpo_s.hit) begin
            rd_data_s = out_r[rd_gpo_s.idx];
            rd_resp_s = RESP_OKAY;
        end else if (rd_gpi_s.hit) begin
            rd_data_s = in_smp_s[rd_gpi_s.idx];
            rd_resp_s = RESP_OKAY;
        end else begin
            rd_data_s = 32'h0000_0000;
            rd_resp_s = RESP_SLVERR;
        end
    end

    // AW/W buffering and B channel; buffers drain together on commit.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            aw_buf_r  <= 1'b0;
            aw_word_r <= 6'd0;
            w_buf_r   <= 1'b0;
            w_data_r  <= 32'h0000_0000;
            w_strb_r  <= 4'h0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            if (aw_hs_s) begin
                aw_buf_r  <= 1'b1;
                aw_word_r <= s_axi.awaddr[7:2];
            end else if (commit_s) begin
                aw_buf_r  <= 1'b0;
            end
            if (w_hs_s) begin
                w_buf_r  <= 1'b1;
                w_data_r <= s_axi.wdata;
                w_strb_r <= s_axi.wstrb;
            end else if (commit_s) begin
                w_buf_r  <= 1'b0;
            end
            if (commit_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= wr_dec_s.hit ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_r && s_axi.bready) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Output registers: byte-merged update on a committed GPO write.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            out_r <= {(MAX_PORTS*32){1'b0}};
        end else begin
            for (int k = 0; k < MAX_PORTS; k++) begin
                if (commit_s && wr_dec_s.hit && (wr_dec_s.idx == 2'(k))) begin
                    out_r[k] <= merge_bytes(out_r[k], w_data_r, w_strb_r);
                end
            end
        end
    end

    // R channel: capture data on the AR handshake, hold until accepted.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0000_0000;
            rresp_r  <= RESP_OKAY;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_data_s;
            rresp_r  <= rd_resp_s;
        end else if (rvalid_r && s_axi.rready) begin
            rvalid_r <= 1'b0;
        end
    end

    assign s_axi.awready = awready_s;
    assign s_axi.wready  = wready_s;
    assign s_axi.arready = arready_s;
    assign s_axi.bvalid  = bvalid_r;
    assign s_axi.bresp   = bresp_r;
    assign s_axi.rvalid  = rvalid_r;
    assign s_axi.rdata   = rdata_r;
    assign s_axi.rresp   = rresp_r;

    // Ports beyond the active count are tied off; their registers never update.
    assign out0 = out_r[0];
    assign out1 = (O_PORT_COUNT > 1) ? out_r[1] : 32'h0000_0000;
    assign out2 = (O_PORT_COUNT > 2) ? out_r[2] : 32'h0000_0000;
    assign out3 = (O_PORT_COUNT > 3) ? out_r[3] : 32'h0000_0000;

    // Protection bits and undecoded address bits are intentionally ignored.
    assign unused_s = ^{s_axi.awprot, s_axi.arprot,
                        s_axi.awaddr[31:8], s_axi.awaddr[1:0],
                        s_axi.araddr[31:8], s_axi.araddr[1:0], in_raw_s};

endmodule

// File: tb/tb_axi_lite_gpio.sv
// Directed self-checking bench for axi_lite_gpio with default parameters.
module tb_axi_lite_gpio;

    logic        clk;
    logic        areset;
    logic [31:0] in0, in1, in2, in3;
    logic [31:0] out0, out1, out2, out3;
    int          checks;
    int          errors;

    axi_lite_gpio_if bus ();

    axi_lite_gpio dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (areset),
        .s_axi        (bus.slave),
        .in0          (in0),
        .in1          (in1),
        .in2          (in2),
        .in3          (in3),
        .out0         (out0),
        .out1         (out1),
        .out2         (out2),
        .out3         (out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Same-cycle AW+W write, then wait (bounded) for and accept the response.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp,
                            input string tag);
        int n;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        n = 0;
        while (!bus.bvalid && n < 10) begin
            tick();
            n++;
        end
        check_eq({tag, "_bvalid"}, 32'(bus.bvalid), 32'h1);
        check_eq({tag, "_bresp"}, 32'(bus.bresp), 32'(exp_resp));
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    // Single read; rvalid must be up right after the AR handshake edge.
    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input string tag);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        check_eq({tag, "_rvalid"}, 32'(bus.rvalid), 32'h1);
        check_eq({tag, "_rdata"}, bus.rdata, exp_data);
        check_eq({tag, "_rresp"}, 32'(bus.rresp), 32'(exp_resp));
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        areset      = 1'b1;
        in0         = 32'h0000_CE00;
        in1         = 32'h1111_1111;
        in2         = 32'h2222_2222;
        in3         = 32'h3333_3333;
        bus.awaddr  = 32'h0;
        bus.awprot  = 3'b000;
        bus.awvalid = 1'b0;
        bus.wdata   = 32'h0;
        bus.wstrb   = 4'h0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = 32'h0;
        bus.arprot  = 3'b000;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        @(negedge clk);
        tick();
        tick();
        areset = 1'b0;

        // Reset state
        check_eq("rst_out0", out0, 32'h0);
        check_eq("rst_out1", out1, 32'h0);
        check_eq("rst_bvalid", 32'(bus.bvalid), 32'h0);
        check_eq("rst_rvalid", 32'(bus.rvalid), 32'h0);
        check_eq("rst_rdata", bus.rdata, 32'h0);
        check_eq("rst_readys", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);

        // GPI read at default offset
        do_read(32'h0000_0010, 32'h0000_CE00, 2'b00, "rd_in0");

        // AW, W and AR in the same cycle
        bus.awaddr  = 32'h0000_0000;
        bus.wdata   = 32'hDEAD_BEEF;
        bus.wstrb   = 4'hF;
        bus.araddr  = 32'h0000_0010;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.arvalid = 1'b1;
        check_eq("same_readys", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        check_eq("same_rvalid", 32'(bus.rvalid), 32'h1);
        check_eq("same_rdata", bus.rdata, 32'h0000_CE00);
        check_eq("same_bvalid_early", 32'(bus.bvalid), 32'h0);
        check_eq("same_awready_buf", 32'(bus.awready), 32'h0);
        tick();
        check_eq("same_bvalid", 32'(bus.bvalid), 32'h1);
        check_eq("same_bresp", 32'(bus.bresp), 32'h0);
        check_eq("same_out0", out0, 32'hDEAD_BEEF);
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        check_eq("same_bvalid_drop", 32'(bus.bvalid), 32'h0);
        check_eq("same_rvalid_drop", 32'(bus.rvalid), 32'h0);

        // Unmapped write and read
        do_write(32'h0000_0004, 32'hBABA_CECE, 4'hF, 2'b10, "wr_unmapped");
        check_eq("unmapped_out0", out0, 32'hDEAD_BEEF);
        check_eq("unmapped_out1", out1, 32'h0);
        do_read(32'h0000_0014, 32'h0, 2'b10, "rd_unmapped");

        // Partial strobe merge, then read back
        do_write(32'h0000_0000, 32'h1234_5678, 4'b0011, 2'b00, "wr_strb");
        check_eq("strb_out0", out0, 32'hDEAD_5678);
        do_read(32'h0000_0000, 32'hDEAD_5678, 2'b00, "rd_out0");

        // Ignored address bits: 0x112 decodes as in0
        do_read(32'h0000_0112, 32'h0000_CE00, 2'b00, "rd_alias");

        // W three cycles ahead of AW, bready held low for two cycles
        bus.wdata  = 32'hA5A5_0F0F;
        bus.wstrb  = 4'hF;
        bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        check_eq("wfirst_wready", 32'(bus.wready), 32'h0);
        check_eq("wfirst_awready", 32'(bus.awready), 32'h1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("wfirst_hold_out0", out0, 32'hDEAD_5678);
            check_eq("wfirst_hold_bvalid", 32'(bus.bvalid), 32'h0);
        end
        bus.awaddr  = 32'h0000_0000;
        bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check_eq("wfirst_pre_out0", out0, 32'hDEAD_5678);
        tick();
        check_eq("wfirst_bvalid", 32'(bus.bvalid), 32'h1);
        check_eq("wfirst_out0", out0, 32'hA5A5_0F0F);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("bhold_bvalid", 32'(bus.bvalid), 32'h1);
            check_eq("bhold_readys", 32'({bus.awready, bus.wready}), 32'h0);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check_eq("bhold_release", 32'(bus.bvalid), 32'h0);
        check_eq("bhold_awready", 32'(bus.awready), 32'h1);

        // Reset while a write response and a read are pending
        bus.awaddr  = 32'h0000_0000;
        bus.wdata   = 32'h1111_2222;
        bus.wstrb   = 4'hF;
        bus.araddr  = 32'h0000_0000;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        tick();
        check_eq("prerst_bvalid", 32'(bus.bvalid), 32'h1);
        check_eq("prerst_out0", out0, 32'h1111_2222);
        areset = 1'b1;
        tick();
        check_eq("midrst_bvalid", 32'(bus.bvalid), 32'h0);
        check_eq("midrst_rvalid", 32'(bus.rvalid), 32'h0);
        check_eq("midrst_out0", out0, 32'h0);
        check_eq("midrst_readys", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);
        areset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_gpio.md
# axi_lite_gpio

AXI4-Lite slave exposing up to four 32-bit general-purpose output registers and up to four 32-bit general-purpose input ports on one register map. Sits on the processor's peripheral interconnect. Output registers drive fabric logic; input ports are sampled by bus reads.

## Interface
- I_PORT_COUNT, default 1: number of active input ports (1–4).
- O_PORT_COUNT, default 1: number of active output registers (1–4).
- GPO_AXI_ADDR_OFFSET, default 0x00: byte address of out0.
- GPI_AXI_ADDR_OFFSET, default 0x10: byte address of in0.
- ADDR_INC, default 4: byte stride between consecutive ports.
- s_axi_aclk  in  1  sole clock.
- s_axi_areset  in  1  synchronous, active-high reset.
- s_axi_awaddr  in  32  write address.
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte-lane enables.
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake.
- s_axi_araddr  in  32  read address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake.
- in0..in3  in  32 each  input ports; ports at index ≥ I_PORT_COUNT are ignored.
- out0..out3  out  32 each  output registers; ports at index ≥ O_PORT_COUNT are driven 0.

## Operation
- Decode uses addr[7:2]; addr[1:0] and addr[31:8] are ignored.
- A GPO hit is GPO_AXI_ADDR_OFFSET + k·ADDR_INC with k < O_PORT_COUNT. A GPI hit is GPI_AXI_ADDR_OFFSET + k·ADDR_INC with k < I_PORT_COUNT.
- Write to a GPO hit updates outk with a byte-wise merge per wstrb, and returns bresp OKAY (2'b00).
- Any other write address is discarded without changing state, and returns bresp SLVERR (2'b10).
- Read of a GPO hit returns the current outk. Read of a GPI hit returns ink. Both return rresp OKAY.
- Any other read address returns rdata 0 with rresp SLVERR.
- Read and write channels are fully independent and may complete in the same cycle.

## Timing
- Reset values: out0..out3 = 0; bvalid = 0; rvalid = 0; rdata = 0; bresp = 0; rresp = 0; AW and W holding buffers empty.
- awready = !aw_buffered && !bvalid. wready = !w_buffered && !bvalid. AW and W are accepted independently, in any order or in the same cycle.
- Once both AW and W are buffered, the register update happens on the next edge. bvalid rises on that same edge and both buffers clear.
- Same-cycle AW+W acceptance gives bvalid one cycle after the handshake.
- bvalid holds until bready is high, then drops on that edge.
- arready = !rvalid. The AR handshake registers rdata/rresp, and rvalid rises on the next edge.
- rvalid holds, with rdata stable, until rready is high.
- Input ports are sampled on the AR handshake edge. With IN_SYNC_EN, the sampled value is the synchronizer output instead.
- Reset asserted mid-transaction aborts it: buffers clear, valids drop, and outputs return to 0 on the reset edge.

## Configuration
- AXI_GPIO_IN_SYNC_EN defined: each in port passes through a two-flop synchronizer, reset to 0, so reads reflect the pin value from 2 cycles earlier.
- Macro undefined: in ports are sampled directly, with no added latency.

## Structure
- Shared package axi_lite_gpio_pkg: response codes RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10, maximum port count 4, and the default offsets and stride.
- Sub-module gpio_in_sync, a 32-bit two-flop synchronizer, instantiated per input port only under AXI_GPIO_IN_SYNC_EN.

## Test plan
- Default parameters, in0 = 0xCE00, read 0x10 -> rdata 0x0000CE00, rresp OKAY, rvalid one cycle after the AR handshake.
- AW, W and AR all asserted in the same cycle (write 0xDEADBEEF to 0x00, read 0x10) -> all three readys high; out0 = 0xDEADBEEF; bresp OKAY; rdata 0x0000CE00.
- Write 0xBABACECE to 0x04 with O_PORT_COUNT = 1 -> bresp SLVERR, out0 stays 0xDEADBEEF. Read 0x14 -> rdata 0, rresp SLVERR.
- out0 = 0xDEADBEEF, then write 0x12345678 with wstrb 4'b0011 -> out0 = 0xDEAD5678. Read 0x00 -> rdata 0xDEAD5678.
- W presented 3 cycles before AW, with bready held low for 2 cycles -> no update until AW arrives; bvalid held; awready and wready stay low while bvalid is high.
- s_axi_areset pulsed while bvalid is high -> next edge: bvalid 0, out0 0, awready/wready/arready 1.
